// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the x^16+x^14+x^13+x^11+1 PRBS stream: SEARCH fill, VERIFY, LOCKED with error counting.
// Optional period measurement when LFSR_CHK_PERIOD_EN is defined; otherwise period outputs are tied to zero.
`timescale 1ns/1ps
module lfsr_checker #(
  parameter int unsigned LOCK_COUNT = 32,
  parameter int unsigned ERR_THRESH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_bit_i,
  input  logic        in_valid_i,
  input  logic        clr_cnt_i,
  output logic        locked_o,
  output logic        bit_err_o,
  output logic [15:0] err_count_o,
  output logic [31:0] bit_count_o,
  output logic [16:1] state_out_o,
  output logic [17:1] period_o,
  output logic        period_valid_o
);

  localparam logic [7:0] LOCK_CNT_W = 8'(LOCK_COUNT);
  localparam logic [3:0] ERR_TH_W   = 4'(ERR_THRESH);

  typedef enum logic [1:0] {S_SEARCH, S_VERIFY, S_LOCKED} state_e;

  state_e      fsm_q, fsm_d;
  logic [16:1] lfsr_q, lfsr_d;
  logic [4:0]  fill_q, fill_d;
  logic [7:0]  match_q, match_d;
  logic [3:0]  miss_q, miss_d;
  logic [3:0]  good_q, good_d;
  logic        locked_q, locked_d;
  logic        bit_err_q, bit_err_d;
  logic [15:0] err_q, err_d;
  logic [31:0] bcnt_q, bcnt_d;

  logic pred;
  logic mism;

  assign pred = lfsr_q[16] ^ lfsr_q[14] ^ lfsr_q[13] ^ lfsr_q[11];
  assign mism = (in_bit_i != pred);

  always_comb begin
    fsm_d     = fsm_q;
    lfsr_d    = lfsr_q;
    fill_d    = fill_q;
    match_d   = match_q;
    miss_d    = miss_q;
    good_d    = good_q;
    err_d     = err_q;
    bcnt_d    = bcnt_q;
    bit_err_d = 1'b0;
    if (in_valid_i) begin
      case (fsm_q)
        S_SEARCH: begin
          lfsr_d = {lfsr_q[15:1], in_bit_i};
          fill_d = fill_q + 5'd1;
          if (fill_d == 5'd16) begin
            fill_d = 5'd0;
            if (lfsr_d != '0) begin
              fsm_d   = S_VERIFY;
              match_d = 8'd0;
            end
          end
        end
        S_VERIFY: begin
          if (mism) begin
            fsm_d  = S_SEARCH;
            fill_d = 5'd0;
          end else begin
            lfsr_d  = {lfsr_q[15:1], pred};
            match_d = match_q + 8'd1;
            if (match_d == LOCK_CNT_W) begin
              fsm_d  = S_LOCKED;
              miss_d = 4'd0;
              good_d = 4'd0;
            end
          end
        end
        S_LOCKED: begin
          // Received errors never corrupt the local copy once locked.
          lfsr_d = {lfsr_q[15:1], pred};
          if (bcnt_q != '1) bcnt_d = bcnt_q + 32'd1;
          if (mism) begin
            bit_err_d = 1'b1;
            if (err_q != '1) err_d = err_q + 16'd1;
            good_d = 4'd0;
            miss_d = miss_q + 4'd1;
            if (miss_d == ERR_TH_W) begin
              fsm_d  = S_SEARCH;
              fill_d = 5'd0;
            end
          end else if (good_q == 4'd15) begin
            good_d = 4'd0;
            miss_d = 4'd0;
          end else begin
            good_d = good_q + 4'd1;
          end
        end
        default: fsm_d = S_SEARCH;
      endcase
    end
    if (clr_cnt_i) begin
      err_d  = '0;
      bcnt_d = '0;
    end
    locked_d = (fsm_d == S_LOCKED);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q     <= S_SEARCH;
      lfsr_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      good_q    <= '0;
      locked_q  <= 1'b0;
      bit_err_q <= 1'b0;
      err_q     <= '0;
      bcnt_q    <= '0;
    end else begin
      fsm_q     <= fsm_d;
      lfsr_q    <= lfsr_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      bit_err_q <= bit_err_d;
      err_q     <= err_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign locked_o    = locked_q;
  assign bit_err_o   = bit_err_q;
  assign err_count_o = err_q;
  assign bit_count_o = bcnt_q;
  assign state_out_o = lfsr_q;

`ifdef LFSR_CHK_PERIOD_EN
  logic [16:1] ref_q;
  logic [17:1] pcnt_q;
  logic [17:1] period_q;
  logic        pvld_q;

  // Reference is the state seen right after entering LOCKED; period is valid bits until it recurs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_q    <= '0;
      pcnt_q   <= '0;
      period_q <= '0;
      pvld_q   <= 1'b0;
    end else if (in_valid_i) begin
      if (fsm_d != S_LOCKED) begin
        ref_q    <= '0;
        pcnt_q   <= '0;
        period_q <= '0;
        pvld_q   <= 1'b0;
      end else if (fsm_q != S_LOCKED) begin
        ref_q  <= lfsr_d;
        pcnt_q <= '0;
      end else if (pcnt_q == '1) begin
        pvld_q <= 1'b0;
      end else if (lfsr_d == ref_q) begin
        period_q <= pcnt_q + 17'd1;
        pvld_q   <= 1'b1;
        pcnt_q   <= '0;
      end else begin
        pcnt_q <= pcnt_q + 17'd1;
      end
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = pvld_q;
`else
  assign period_o       = '0;
  assign period_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: vector table for lock-up/single errors/clear, hand sequences for lock loss, zeros, gaps and reset.
`timescale 1ns/1ps
module tb_lfsr_checker;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_bit_i;
  logic        in_valid_i;
  logic        clr_cnt_i;
  logic        locked_o;
  logic        bit_err_o;
  logic [15:0] err_count_o;
  logic [31:0] bit_count_o;
  logic [16:1] state_out_o;
  logic [17:1] period_o;
  logic        period_valid_o;

  typedef struct {
    logic        locked;
    logic        bit_err;
    logic [15:0] err;
    logic [31:0] bcnt;
    int          st_bits;
    logic [16:1] st;
  } exp_t;

  typedef struct {
    logic v;
    logic f;
    logic c;
    exp_t e;
  } vec_t;

  localparam int NB = 80;

  exp_t        exp_q[$];
  vec_t        tbl[NB];
  int          checks = 0;
  int          failures = 0;
  logic [16:1] g;
  logic        use_gen;

  lfsr_checker dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_bit_i(in_bit_i), .in_valid_i(in_valid_i),
    .clr_cnt_i(clr_cnt_i), .locked_o(locked_o), .bit_err_o(bit_err_o),
    .err_count_o(err_count_o), .bit_count_o(bit_count_o), .state_out_o(state_out_o),
    .period_o(period_o), .period_valid_o(period_valid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [16:1] mask(input int b);
    logic [16:1] m;
    m = '0;
    for (int i = 1; i <= 16; i++) if (i <= b) m[i] = 1'b1;
    return m;
  endfunction

  function automatic exp_t mk(input logic lk, input logic be, input logic [15:0] ec,
                              input logic [31:0] bc, input int sb);
    exp_t e;
    e.locked = lk; e.bit_err = be; e.err = ec; e.bcnt = bc; e.st_bits = sb; e.st = '0;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = exp_q.pop_front();
      cmp("locked", 32'(locked_o), 32'(e.locked));
      cmp("bit_err", 32'(bit_err_o), 32'(e.bit_err));
      cmp("err_count", 32'(err_count_o), 32'(e.err));
      cmp("bit_count", bit_count_o, e.bcnt);
      cmp("state_out", 32'(state_out_o), 32'(e.st));
`ifndef LFSR_CHK_PERIOD_EN
      cmp("period", 32'(period_o), 32'd0);
      cmp("period_valid", 32'(period_valid_o), 32'd0);
`endif
    end
  endtask

  // Drive one cycle; generator state only advances on valid cycles.
  task automatic step(input logic v, input logic f, input logic c, input exp_t e);
    logic fb;
    @(negedge clk_i);
    in_valid_i = v;
    clr_cnt_i  = c;
    if (v && use_gen) begin
      fb = g[16] ^ g[14] ^ g[13] ^ g[11];
      g = {g[15:1], fb};
      in_bit_i = fb ^ f;
    end else if (v) begin
      in_bit_i = f;
    end else begin
      in_bit_i = 1'($urandom_range(0, 1));
    end
    e.st = use_gen ? (g & mask(e.st_bits)) : '0;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    check_out();
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_locked"}, 32'(locked_o), 32'd0);
    cmp({tag, "_bit_err"}, 32'(bit_err_o), 32'd0);
    cmp({tag, "_err_count"}, 32'(err_count_o), 32'd0);
    cmp({tag, "_bit_count"}, bit_count_o, 32'd0);
    cmp({tag, "_state"}, 32'(state_out_o), 32'd0);
    cmp({tag, "_period"}, 32'(period_o), 32'd0);
    cmp({tag, "_period_valid"}, 32'(period_valid_o), 32'd0);
  endtask

  initial begin
    int          k;
    logic [31:0] bc;
    logic [15:0] ec;
    logic        v;
    rst_ni = 1'b0; in_valid_i = 1'b0; in_bit_i = 1'b0; clr_cnt_i = 1'b0; use_gen = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Clean lock-up with gaps, then one lone error and an error coinciding with clr_cnt.
    g = 16'b1010110011100001;
    k = 0; bc = '0; ec = '0;
    for (int i = 0; i < NB; i++) begin
      tbl[i].v = !(i > 20 && (i % 6) == 1);
      tbl[i].f = 1'b0;
      tbl[i].c = 1'b0;
      if (tbl[i].v) begin
        k++;
        if (k == 55) tbl[i].f = 1'b1;
        if (k == 60) begin tbl[i].f = 1'b1; tbl[i].c = 1'b1; end
        if (k > 48) begin
          bc++;
          if (tbl[i].f) ec++;
        end
        if (tbl[i].c) begin bc = '0; ec = '0; end
      end
      tbl[i].e = mk(k >= 48, tbl[i].v && tbl[i].f, ec, bc, (k >= 16) ? 16 : k);
    end
    for (int i = 0; i < NB; i++) step(tbl[i].v, tbl[i].f, tbl[i].c, tbl[i].e);

    // 16 good bits clear the miss history, then 8 consecutive errors drop lock.
    for (int i = 0; i < 16; i++) begin
      bc++;
      step(1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, ec, bc, 16));
    end
    for (int i = 0; i < 8; i++) begin
      bc++; ec++;
      step(1'b1, 1'b1, 1'b0, mk(i < 7, 1'b1, ec, bc, 16));
    end
    for (int j = 1; j <= 48; j++) step(1'b1, 1'b0, 1'b0, mk(j >= 48, 1'b0, ec, bc, 16));
    bc++;
    step(1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, ec, bc, 16));
    cmp("err_count_after_relock", 32'(err_count_o), 32'd8);

    // Asynchronous reset while locked clears everything before any clock edge.
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;

    use_gen = 1'b0;
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 16'd0, 32'd0, 0));

    @(negedge clk_i);
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Random valid gaps from a fresh reset.
    use_gen = 1'b1;
    g = 16'hBEEF;
    k = 0;
    for (int n = 0; n < 600 && k < 60; n++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) k++;
      step(v, 1'b0, 1'b0, mk(k >= 48, 1'b0, 16'd0, (k > 48) ? 32'(k - 48) : 32'd0,
                             (k >= 16) ? 16 : k));
    end
    cmp("gap_run_bound", 32'(k), 32'd60);

`ifdef LFSR_CHK_PERIOD_EN
    begin
      int   lb;
      int   n;
      logic fb;
      lb = k - 48;
      n = 0;
      while (!period_valid_o && n < 70000) begin
        @(negedge clk_i);
        fb = g[16] ^ g[14] ^ g[13] ^ g[11];
        g = {g[15:1], fb};
        in_bit_i = fb;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        lb++; n++;
      end
      cmp("period_valid_seen", 32'(period_valid_o), 32'd1);
      cmp("period_value", 32'(period_o), 32'd65535);
      cmp("period_locked_bits", 32'(lb), 32'd65535);
    end
`endif

    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 16-bit Fibonacci LFSR generator: consumes the serial bit stream produced by the generator, self-synchronises a local LFSR copy to it, then predicts and checks every following bit. Used in hardware-security experiments to confirm a PRBS source is intact, count bit errors/tampering on the link, and optionally measure sequence period. Sits at the far end of the link from the `lfsr` generator, one bit per valid cycle.

## Interface
- LOCK_COUNT, 32: consecutive correct predicted bits in VERIFY needed to assert lock (1..255).
- ERR_THRESH, 8: errors without an intervening run of 16 good bits that drop lock (1..15).
- clock  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- in_bit  input  1  received serial bit (generator's newly shifted-in bit).
- in_valid  input  1  in_bit qualifier; all state advances only when high.
- clr_cnt  input  1  synchronous clear of err_count and bit_count; priority over increments.
- locked  output  1  high in LOCKED state.
- bit_err  output  1  one-cycle pulse: the bit sampled on the previous valid edge mismatched in LOCKED.
- err_count  output  16  saturating count of LOCKED mismatches.
- bit_count  output  32  saturating count of valid bits checked in LOCKED.
- state_out  output  [16:1]  local LFSR state.
- period  output  [17:1]  measured period (macro only).
- period_valid  output  1  period holds a measurement (macro only).

## Operation
- Polynomial x^16+x^14+x^13+x^11+1: fb = s[16]^s[14]^s[13]^s[11]; next state = {s[15:1], new_bit}.
- Predicted bit = fb of current local state.
- SEARCH: each valid bit shifts in_bit into local state; 5-bit fill counter counts to 16. At 16: all-zero state -> restart fill (stay SEARCH); otherwise -> VERIFY, match counter = 0.
- VERIFY: local state shifts predicted bit. in_bit == prediction -> match counter +1; reaching LOCK_COUNT -> LOCKED. Mismatch -> SEARCH, fill counter = 0, mismatching bit discarded.
- LOCKED: local state shifts predicted bit (received errors never enter state). bit_count +1 per valid bit. Mismatch -> bit_err pulse, err_count +1, miss counter +1; 16 consecutive good bits reset miss counter to 0. Miss counter reaching ERR_THRESH -> SEARCH, fill counter = 0.
- Counters saturate at all-ones; never wrap. err_count/bit_count persist across loss of lock; cleared only by reset or clr_cnt.
- in_valid low: no state, counter or output change; bit_err low.

## Timing
- Reset (async assert, any state): SEARCH, state_out 0, all counters 0, locked 0, bit_err 0, period 0, period_valid 0. Deassertion synchronous to clock by upstream.
- All outputs registered; change only on rising edge sampling in_valid=1 (bit_err also falls on next edge).
- Continuous valid from fresh reset, clean stream: fill completes edge 16, locked high after edge 16+LOCK_COUNT (edge 48 default).
- bit_err high for exactly the cycle after the offending edge.
- clr_cnt with a simultaneous error: counters read 0 next cycle; bit_err still pulses.
- Lock loss: locked falls after the edge sampling the ERR_THRESH-th miss.

## Configuration
- LFSR_CHK_PERIOD_EN defined: on entry to LOCKED, state_out captured as reference; 17-bit counter counts valid bits; when state_out next equals reference, period <= count, period_valid = 1, counter restarts. Counter saturates at 2^17-1 with period_valid 0. Cleared on leaving LOCKED.
- Undefined: period and period_valid tied to 0; no capture logic.

## Test plan
- Generator seeded 16'b1010110011100001, continuous valid -> locked 1 after edge 48, bit_count increments each edge, err_count 0, bit_err never asserted.
- Locked; flip one bit -> bit_err one cycle, err_count 1, locked stays 1, next predicted bits match.
- Locked; 8 consecutive flipped bits -> locked 0 after 8th; clean stream resumes -> relock after 48 further valid bits; err_count 8.
- All-zero input for 100 bits -> remains SEARCH, locked 0, bit_count 0.
- Random in_valid gaps on clean stream -> lock after 48 valid bits regardless of gaps; async reset while locked -> all outputs 0 immediately, relock from scratch.
- LFSR_CHK_PERIOD_EN defined, clean stream -> period 65535, period_valid 1 after 65535 valid bits in LOCKED; undefined build -> period 0 throughout.
